// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width
// and the 1-bit full-adder cell the slice is built from.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
        return {co, s};
    endfunction

endpackage

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit ripple adder; c3 is the carry into the top bit so the
// caller can form signed overflow as c3 ^ cout.
module nibble_adder_slice
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            {carry[i+1], sum[i]} = full_add(a[i], b[i], carry[i]);
        end
    end

    assign cout = carry[NIBBLE_W];
    assign c3   = carry[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract sequencer: one shared 4-bit slice processes one nibble per
// clock, LSB first, with operands and results exchanged over valid/ready.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W      = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    input  logic         Sub,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] Sum,
    output logic         Cout,
    output logic         Ovf,
    output logic         busy
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t                                 state;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]       a_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]       b_reg;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]       sum_reg;
    logic                                   carry;
    logic [IDX_W-1:0]                       idx;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic                slice_c3;

    nibble_adder_slice u_slice (
        .a    (a_reg[idx]),
        .b    (b_reg[idx]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    assign Sum = sum_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        // Subtract folds into an add of ~B with carry-in forced to 1.
                        a_reg    <= A;
                        b_reg    <= Sub ? ~B : B;
                        carry    <= Sub ? 1'b1 : Cin;
                        idx      <= '0;
                        state    <= ST_RUN;
                        op_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum_reg[idx] <= slice_sum;
                    carry        <= slice_cout;
                    if (idx == IDX_W'(NIBBLES - 1)) begin
                        Cout      <= slice_cout;
                        Ovf       <= slice_c3 ^ slice_cout;
                        state     <= ST_DONE;
                        res_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    op_ready  <= 1'b1;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed vectors with literal results,
// then randomized traffic compared every cycle against an arithmetic model.
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Result of one operation from plain integer arithmetic: {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ov;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    // Transaction-level model of what the outputs must show after each edge.
    logic         m_ready, m_valid, m_busy, m_cout, m_ovf;
    logic [W-1:0] m_sum;
    logic [W+1:0] m_pend;
    int           m_left;
    bit           cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0;
            m_sum   <= '0;   m_cout  <= 1'b0; m_ovf  <= 1'b0;
            m_left  <= 0;
        end else if (m_ready && op_valid) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b1;
            m_left  <= NIBBLES;
            m_pend  <= ref_op(A, B, Cin, Sub);
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                {m_ovf, m_cout, m_sum} <= m_pend;
            end
        end else if (m_valid && res_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
            m_busy  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("op_ready", 64'(op_ready), 64'(m_ready));
            chk("res_valid", 64'(res_valid), 64'(m_valid));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("cout", 64'(Cout), 64'(m_cout));
            chk("ovf", 64'(Ovf), 64'(m_ovf));
            if (m_left == 0) chk("sum", 64'(Sum), 64'(m_sum));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!op_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) chk("op_ready_timeout", 64'(op_ready), 64'd1);
    endtask

    // Issue one operation; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        wait_ready();
        op_valid = 1'b1; A = a; B = b; Cin = cin; Sub = sub;
        @(negedge clk);
        op_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (res_valid) break;
        end
        if (!res_valid) chk("res_valid_timeout", 64'(res_valid), 64'd1);
    endtask

    task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input logic [W-1:0] es,
                           input logic ec, input logic eo);
        int lat;
        res_ready = 1'b1;
        start_op(a, b, cin, sub);
        wait_result(lat);
        chk({name, "_latency"}, 64'(lat), 64'(NIBBLES));
        chk({name, "_sum"}, 64'(Sum), 64'(es));
        chk({name, "_cout"}, 64'(Cout), 64'(ec));
        chk({name, "_ovf"}, 64'(Ovf), 64'(eo));
        @(negedge clk);
        chk({name, "_ready_after"}, 64'(op_ready), 64'd1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; op_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_op_ready", 64'(op_ready), 64'd1);
        chk("reset_res_valid", 64'(res_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_sum", 64'(Sum), 64'd0);
        cmp_en = 1'b1;

        run_vec("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_vec("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_vec("add_cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_vec("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_vec("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_vec("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_vec("sub_equal", 16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Backpressure in DONE with a competing request pending.
        res_ready = 1'b0;
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_result(lat);
        op_valid = 1'b1; A = 16'h0F0F; B = 16'h00F1; Cin = 1'b0; Sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_sum", 64'(Sum), 64'h3333);
            chk("bp_op_ready", 64'(op_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", 64'(op_ready), 64'd1);
        @(negedge clk);
        op_valid = 1'b0;
        chk("bp_accepted", 64'(busy), 64'd1);
        wait_result(lat);
        chk("bp_second_sum", 64'(Sum), 64'h1000);

        // Reset in the middle of RUN.
        @(negedge clk);
        start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_op_ready", 64'(op_ready), 64'd1);
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_sum", 64'(Sum), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        run_vec("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Random traffic with random backpressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            op_valid  = 1'($urandom);
            A         = W'($urandom);
            B         = W'($urandom);
            Cin       = 1'($urandom);
            Sub       = 1'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 399) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1; op_valid = 1'b0; res_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
